// File: rtl/multiphase_timer_if.sv
// Control/status bundle for multiphase_timer: run/step/width requests in, phase outputs back.
interface multiphase_timer_if #(
  parameter int NPHASE = 4,
  parameter int PW_W   = 3,
  parameter int CNT_W  = 8
);
  logic              HALTN;
  logic              STEP;
  logic [PW_W-1:0]   PWIDTH;
  logic [NPHASE-1:0] PHASE;
  logic              CLK;
  logic              PCLK;
  logic              CYCEND;
  logic              RUNNING;
  logic [CNT_W-1:0]  CYCCNT;

  modport master (output HALTN, STEP, PWIDTH,
                  input  PHASE, CLK, PCLK, CYCEND, RUNNING, CYCCNT);
  modport slave  (input  HALTN, STEP, PWIDTH,
                  output PHASE, CLK, PCLK, CYCEND, RUNNING, CYCCNT);
endinterface

// File: rtl/multiphase_timer.sv
// Multi-phase timing generator: splits INCLK into machine cycles of NPHASE one-hot
// phases of pw+1 periods each, with boundary-only halt, single-step and cycle counter.
module multiphase_timer_cell #(
  parameter int PH_W = 2,
  parameter int IDX  = 0
) (
  input  logic            active,
  input  logic [PH_W-1:0] ph,
  output logic            hit
);
  assign hit = active & (ph == PH_W'(IDX));
endmodule

module multiphase_timer #(
  parameter int NPHASE = 4,
  parameter int PW_W   = 3,
  parameter int CNT_W  = 8
) (
  input logic                INCLK,
  input logic                RSTN,
  multiphase_timer_if.slave  bus
);
  localparam int PH_W = (NPHASE > 2) ? $clog2(NPHASE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPHASE-1);

  typedef enum logic {IDLE, ACTIVE} mode_e;

  mode_e             mode_q, mode_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [PW_W-1:0]   sc_q, sc_d;
  logic [PW_W-1:0]   pw_q, pw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_q;
  logic              step_edge;
  logic              active;
  logic              cyc_end;

  assign step_edge = bus.STEP & ~step_q;
  assign active    = (mode_q == ACTIVE);
  assign cyc_end   = active & (ph_q == PH_LAST) & (sc_q == pw_q);

  always_ff @(posedge INCLK or negedge RSTN) begin
    if (!RSTN) begin
      mode_q <= IDLE;
      ph_q   <= '0;
      sc_q   <= '0;
      pw_q   <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      ph_q   <= ph_d;
      sc_q   <= sc_d;
      pw_q   <= pw_d;
      cnt_q  <= cnt_d;
      step_q <= bus.STEP;
    end
  end

  always_comb begin
    mode_d = mode_q;
    ph_d   = ph_q;
    sc_d   = sc_q;
    pw_d   = pw_q;
    cnt_d  = cnt_q;
    unique case (mode_q)
      IDLE: begin
        if (bus.HALTN | step_edge) begin
          mode_d = ACTIVE;
          ph_d   = '0;
          sc_d   = '0;
          pw_d   = bus.PWIDTH;
        end
      end
      ACTIVE: begin
        if (sc_q != pw_q) begin
          sc_d = sc_q + PW_W'(1);
        end else if (ph_q != PH_LAST) begin
          sc_d = '0;
          ph_d = ph_q + PH_W'(1);
        end else begin
          // HALTN only matters here, so glitches inside a cycle are ignored
          cnt_d = cnt_q + CNT_W'(1);
          sc_d  = '0;
          ph_d  = '0;
          if (bus.HALTN) pw_d   = bus.PWIDTH;
          else           mode_d = IDLE;
        end
      end
      default: mode_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NPHASE; i++) begin : g_ph
    multiphase_timer_cell #(.PH_W(PH_W), .IDX(i)) u_cell (
      .active (active),
      .ph     (ph_q),
      .hit    (bus.PHASE[i])
    );
  end

  assign bus.CLK     = bus.PHASE[0];
  assign bus.PCLK    = bus.PHASE[1];
  assign bus.CYCEND  = cyc_end;
  assign bus.RUNNING = active;
  assign bus.CYCCNT  = cnt_q;
endmodule

// File: tb/tb_multiphase_timer.sv
// Directed bench for multiphase_timer: default 4-phase DUT plus a 2-phase, 2-bit-counter DUT.
module tb_multiphase_timer;
  logic INCLK = 1'b0;
  logic RSTN  = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 INCLK = ~INCLK;

  multiphase_timer_if #(.NPHASE(4), .PW_W(3), .CNT_W(8)) b1 ();
  multiphase_timer_if #(.NPHASE(2), .PW_W(3), .CNT_W(2)) b2 ();

  multiphase_timer #(.NPHASE(4), .PW_W(3), .CNT_W(8)) dut (
    .INCLK (INCLK), .RSTN (RSTN), .bus (b1.slave));
  multiphase_timer #(.NPHASE(2), .PW_W(3), .CNT_W(2)) dut2 (
    .INCLK (INCLK), .RSTN (RSTN), .bus (b2.slave));

  task automatic tick();
    @(posedge INCLK); #1;
  endtask

  task automatic do_reset(input logic [2:0] pw);
    b1.HALTN = 1'b0; b1.STEP = 1'b0; b1.PWIDTH = pw;
    b2.HALTN = 1'b0; b2.STEP = 1'b0; b2.PWIDTH = 3'd0;
    RSTN = 1'b0;
    repeat (2) @(posedge INCLK);
    #1 RSTN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3'd1);
    n_cmp++;
    if ({b1.PHASE, b1.CLK, b1.PCLK, b1.CYCEND, b1.RUNNING} !== 8'h00 || b1.CYCCNT !== 8'd0) begin
      n_err++;
      $display("FAIL reset: got phase=%b clk=%b pclk=%b cycend=%b run=%b cnt=%0d want all 0",
               b1.PHASE, b1.CLK, b1.PCLK, b1.CYCEND, b1.RUNNING, b1.CYCCNT);
    end
    tick();
    n_cmp++;
    if (b1.PHASE !== 4'b0000) begin
      n_err++; $display("FAIL reset_idle_hold: got %b want 0000", b1.PHASE);
    end
  endtask

  task automatic test_run();
    logic [3:0] e;
    do_reset(3'd1);
    b1.HALTN = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      e = 4'b0001 << ((k / 2) % 4);
      n_cmp++;
      if (b1.PHASE !== e || b1.CYCEND !== (k % 8 == 7) || b1.CYCCNT !== 8'(k / 8) ||
          b1.CLK !== e[0] || b1.PCLK !== e[1] || b1.RUNNING !== 1'b1) begin
        n_err++;
        $display("FAIL run k=%0d: got phase=%b cycend=%b cnt=%0d clk=%b pclk=%b want phase=%b cycend=%b cnt=%0d",
                 k, b1.PHASE, b1.CYCEND, b1.CYCCNT, b1.CLK, b1.PCLK, e, (k % 8 == 7), k / 8);
      end
    end
    tick();
    n_cmp++;
    if (b1.PHASE !== 4'b0001 || b1.CYCCNT !== 8'd3) begin
      n_err++; $display("FAIL run_wrap: got phase=%b cnt=%0d want 0001 cnt=3", b1.PHASE, b1.CYCCNT);
    end
  endtask

  task automatic test_halt();
    do_reset(3'd1);
    b1.HALTN = 1'b1;
    repeat (3) tick();          // period 2, phase 1
    b1.HALTN = 1'b0;
    tick();                     // period 3: glitch not at cycle end
    b1.HALTN = 1'b1;
    repeat (5) tick();          // period 8
    n_cmp++;
    if (b1.PHASE !== 4'b0001 || b1.RUNNING !== 1'b1 || b1.CYCCNT !== 8'd1) begin
      n_err++; $display("FAIL halt_glitch: got phase=%b run=%b cnt=%0d want 0001 1 1",
                        b1.PHASE, b1.RUNNING, b1.CYCCNT);
    end
    repeat (2) tick();          // period 10, phase 1 of second cycle
    b1.HALTN = 1'b0;
    repeat (5) tick();          // period 15
    n_cmp++;
    if (b1.PHASE !== 4'b1000 || b1.CYCEND !== 1'b1) begin
      n_err++; $display("FAIL halt_finish: got phase=%b cycend=%b want 1000 1", b1.PHASE, b1.CYCEND);
    end
    tick();
    n_cmp++;
    if (b1.PHASE !== 4'b0000 || b1.RUNNING !== 1'b0 || b1.CYCCNT !== 8'd2 || b1.CYCEND !== 1'b0) begin
      n_err++; $display("FAIL halt_idle: got phase=%b run=%b cnt=%0d cycend=%b want 0000 0 2 0",
                        b1.PHASE, b1.RUNNING, b1.CYCCNT, b1.CYCEND);
    end
    repeat (2) tick();
    n_cmp++;
    if (b1.PHASE !== 4'b0000 || b1.CYCCNT !== 8'd2) begin
      n_err++; $display("FAIL halt_stays: got phase=%b cnt=%0d want 0000 2", b1.PHASE, b1.CYCCNT);
    end
  endtask

  task automatic test_step();
    logic [3:0] e;
    logic [3:0] seq [4];
    do_reset(3'd0);
    tick();
    b1.STEP = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      e = (k < 4) ? (4'b0001 << k) : 4'b0000;
      n_cmp++;
      if (b1.PHASE !== e || b1.CYCEND !== (k == 3) || b1.CYCCNT !== ((k < 4) ? 8'd0 : 8'd1)) begin
        n_err++; $display("FAIL step k=%0d: got phase=%b cycend=%b cnt=%0d want phase=%b",
                          k, b1.PHASE, b1.CYCEND, b1.CYCCNT, e);
      end
    end
    b1.STEP = 1'b0;
    tick();
    // second step, with an extra STEP edge mid-cycle that must be ignored
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      b1.STEP = (k == 0 || k == 2);
      tick();
      e = (k < 4) ? seq[k] : 4'b0000;
      n_cmp++;
      if (b1.PHASE !== e) begin
        n_err++; $display("FAIL step2 k=%0d: got %b want %b", k, b1.PHASE, e);
      end
    end
    n_cmp++;
    if (b1.CYCCNT !== 8'd2 || b1.RUNNING !== 1'b0) begin
      n_err++; $display("FAIL step_count: got cnt=%0d run=%b want 2 0", b1.CYCCNT, b1.RUNNING);
    end
  endtask

  task automatic test_pwidth();
    logic [3:0] e;
    do_reset(3'd0);
    b1.HALTN = 1'b1;
    repeat (3) tick();          // phase 2
    b1.PWIDTH = 3'd3;
    tick();
    n_cmp++;
    if (b1.PHASE !== 4'b1000 || b1.CYCEND !== 1'b1) begin
      n_err++; $display("FAIL pw_old: got phase=%b cycend=%b want 1000 1", b1.PHASE, b1.CYCEND);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      e = 4'b0001 << (k / 4);
      n_cmp++;
      if (b1.PHASE !== e || b1.CYCEND !== (k == 15) || b1.CYCCNT !== 8'd1) begin
        n_err++; $display("FAIL pw_new k=%0d: got phase=%b cycend=%b cnt=%0d want phase=%b",
                          k, b1.PHASE, b1.CYCEND, b1.CYCCNT, e);
      end
    end
    tick();
    n_cmp++;
    if (b1.PHASE !== 4'b0001 || b1.CYCCNT !== 8'd2) begin
      n_err++; $display("FAIL pw_next: got phase=%b cnt=%0d want 0001 2", b1.PHASE, b1.CYCCNT);
    end
  endtask

  task automatic test_async_reset();
    do_reset(3'd2);
    b1.HALTN = 1'b1;
    repeat (19) tick();         // second cycle, phase 2 first period
    n_cmp++;
    if (b1.PHASE !== 4'b0100 || b1.CYCCNT !== 8'd1) begin
      n_err++; $display("FAIL arst_pre: got phase=%b cnt=%0d want 0100 1", b1.PHASE, b1.CYCCNT);
    end
    #2 RSTN = 1'b0;
    #1;
    n_cmp++;
    if (b1.PHASE !== 4'b0000 || b1.RUNNING !== 1'b0 || b1.CYCCNT !== 8'd0 || b1.CYCEND !== 1'b0) begin
      n_err++; $display("FAIL arst_drop: got phase=%b run=%b cnt=%0d want 0000 0 0",
                        b1.PHASE, b1.RUNNING, b1.CYCCNT);
    end
    #1 RSTN = 1'b1;
    #1;
    n_cmp++;
    if (b1.PHASE !== 4'b0000) begin
      n_err++; $display("FAIL arst_release: got %b want 0000", b1.PHASE);
    end
    tick();
    n_cmp++;
    if (b1.PHASE !== 4'b0001 || b1.CYCCNT !== 8'd0) begin
      n_err++; $display("FAIL arst_restart: got phase=%b cnt=%0d want 0001 0", b1.PHASE, b1.CYCCNT);
    end
  endtask

  task automatic test_wrap2();
    logic [1:0] ecnt;
    do_reset(3'd1);
    b2.HALTN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      ecnt = 2'(c);
      n_cmp++;
      if (b2.CLK !== 1'b1 || b2.PCLK !== 1'b0 || b2.CYCCNT !== ecnt) begin
        n_err++; $display("FAIL wrap2_clk c=%0d: got clk=%b pclk=%b cnt=%0d want 1 0 %0d",
                          c, b2.CLK, b2.PCLK, b2.CYCCNT, ecnt);
      end
      tick();
      n_cmp++;
      if (b2.CLK !== 1'b0 || b2.PCLK !== 1'b1 || b2.CYCEND !== 1'b1) begin
        n_err++; $display("FAIL wrap2_pclk c=%0d: got clk=%b pclk=%b cycend=%b want 0 1 1",
                          c, b2.CLK, b2.PCLK, b2.CYCEND);
      end
    end
    tick();
    n_cmp++;
    if (b2.CYCCNT !== 2'd0 || b2.CLK !== 1'b1) begin
      n_err++; $display("FAIL wrap2_cnt: got cnt=%0d clk=%b want 0 1", b2.CYCCNT, b2.CLK);
    end
  endtask

  initial begin
    b1.HALTN = 1'b0; b1.STEP = 1'b0; b1.PWIDTH = 3'd0;
    b2.HALTN = 1'b0; b2.STEP = 1'b0; b2.PWIDTH = 3'd0;
    test_reset();
    test_run();
    test_halt();
    test_step();
    test_pwidth();
    test_async_reset();
    test_wrap2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multiphase_timer.md
# multiphase_timer

Parametrised multi-phase timing generator that divides the free-running INCLK into machine cycles of NPHASE non-overlapping phases, each PWIDTH+1 INCLK periods long. Successor to the fixed two-output pulse timer. Adds a programmable phase count and width, a clean halt that only stops at a machine-cycle boundary, single-step, a cycle-end strobe and a machine-cycle counter. Drives the CPU sequencer phase inputs; CLK/PCLK remain for legacy consumers.

## Interface
- NPHASE, 4, number of phases per machine cycle (2..16)
- PW_W, 3, width of phase-width control PWIDTH
- CNT_W, 8, width of machine-cycle counter CYCCNT
- INCLK  in  1  master clock; all state changes on posedge
- RSTN  in  1  reset; asynchronous, active-low
- HALTN  in  1  run enable; low requests halt at the next cycle boundary
- STEP  in  1  single-step request; rising edge (detected in INCLK domain) honoured only while IDLE
- PWIDTH  in  PW_W  phase length minus one, in INCLK periods
- PHASE  out  NPHASE  one-hot active phase; all-zero when IDLE
- CLK  out  1  equals PHASE[0]
- PCLK  out  1  equals PHASE[1]
- CYCEND  out  1  high during the final INCLK period of each machine cycle
- RUNNING  out  1  high while ACTIVE
- CYCCNT  out  CNT_W  completed machine cycles, wraps to 0

## Operation
- State: mode {IDLE, ACTIVE}, phase index ph (clog2(NPHASE) bits), sub-counter sc (PW_W bits), latched width pw (PW_W bits), step_q, CYCCNT.
- All outputs decode registered state only; no combinational input-to-output path.
- Reset (RSTN low, async): mode=IDLE, ph=0, sc=0, pw=0, step_q=0, CYCCNT=0; thus PHASE=0, CLK=PCLK=CYCEND=RUNNING=0.
- step_q <= STEP every edge; step_edge = STEP & ~step_q.
- IDLE: if HALTN=1 or step_edge -> ACTIVE, ph=0, sc=0, pw<=PWIDTH. Otherwise hold.
- ACTIVE, sc != pw: sc++.
- ACTIVE, sc == pw, ph != NPHASE-1: sc=0, ph++.
- ACTIVE, sc == pw, ph == NPHASE-1 (cycle end): CYCCNT++ (mod 2^CNT_W); sc=0, ph=0; if HALTN=1 stay ACTIVE and pw<=PWIDTH, else -> IDLE.
- PHASE[i] = ACTIVE & (ph==i). CYCEND = ACTIVE & ph==NPHASE-1 & sc==pw. RUNNING = ACTIVE.
- STEP edges while ACTIVE are ignored (not queued).

## Timing
- Start latency: PHASE[0] rises one INCLK edge after HALTN=1 (or STEP edge) is sampled in IDLE.
- Each phase lasts exactly pw+1 INCLK periods; machine cycle = NPHASE*(pw+1) periods; back-to-back cycles have no gap (PHASE[NPHASE-1] falls on the same edge PHASE[0] rises).
- PWIDTH is sampled only at cycle start; mid-cycle changes take effect next cycle.
- HALTN is sampled only at the cycle-end edge (and in IDLE): a low pulse that returns high before cycle end has no effect; a low at cycle end finishes the current cycle fully, then PHASE=0.
- Step with HALTN low: exactly one full machine cycle, then IDLE.
- HALTN=1 and step_edge together in IDLE: one start, continues running.
- Reset mid-cycle: outputs drop to 0 immediately (asynchronous); after RSTN release, restart follows the IDLE rule from phase 0.
- CYCCNT increments on the cycle-end edge; wraps 2^CNT_W-1 -> 0.

## Test plan
- Defaults, PWIDTH=1, HALTN=1 after reset: PHASE sequence 0001,0001,0010,0010,0100,0100,1000,1000 repeating; CYCEND high on 8th period only; CYCCNT=3 after 24 periods of running.
- Halt mid-cycle: HALTN low during phase 1 of cycle 2 -> cycle completes through PHASE[3], then PHASE=0, RUNNING=0, CYCCNT=2; short HALTN glitch within a phase causes no change.
- Single-step: HALTN=0, PWIDTH=0, STEP held high 10 periods -> exactly one cycle (4 periods), CYCCNT +1; a second STEP edge during the cycle ignored.
- PWIDTH change: PWIDTH 0->3 during phase 2 -> current cycle stays 4 periods, next cycle 16 periods.
- Async reset in phase 2 of a PWIDTH=2 cycle: all outputs 0 without an INCLK edge; after release with HALTN=1, PHASE[0] one edge later, CYCCNT=0.
- NPHASE=2, CNT_W=2: CLK/PCLK alternate; CYCCNT wraps 3->0 at the 4th cycle end.
